// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared types for the multicycle RV32I control FSM.
package multicycle_ctrl_pkg;
  localparam int INST_WIDTH = 32;
  localparam int CNT_WIDTH = 32;

  typedef enum logic [6:0] {
    OPCODE_INVALID = 7'h00,
    OP_LOAD        = 7'h03,
    OP_IMM         = 7'h13,
    OP_AUIPC       = 7'h17,
    OP_STORE       = 7'h23,
    OP_REG         = 7'h33,
    OP_LUI         = 7'h37,
    OP_BRANCH      = 7'h63,
    OP_JALR        = 7'h67,
    OP_JAL         = 7'h6F
  } opcode_e;

  typedef enum logic [2:0] {IMM_RTYPE, IMM_ITYPE, IMM_STYPE, IMM_BTYPE, IMM_UTYPE, IMM_JTYPE} imm_sel_e;
  typedef enum logic [2:0] {ALUOP_NONE, ALUOP_ADD, ALUOP_SUB, ALUOP_PASS_B, ALUOP_FUNCT3, ALUOP_FUNCT7} alu_op_e;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} ctrl_state_e;
  typedef enum logic [1:0] {PC_PC4, PC_BRANCH, PC_ALU} pc_sel_e;
  typedef enum logic {A_RS1, A_PC} alu_a_sel_e;
  typedef enum logic {B_RS2, B_IMM} alu_b_sel_e;

  typedef struct packed {
    imm_sel_e   imm_sel;
    alu_op_e    alu_op;
    alu_a_sel_e alu_a_sel;
    alu_b_sel_e alu_b_sel;
    wb_sel_e    wb_sel;
    pc_sel_e    pc_sel;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       rf_we;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_RESET = '{
    imm_sel: IMM_RTYPE, alu_op: ALUOP_NONE, alu_a_sel: A_RS1, alu_b_sel: B_RS2,
    wb_sel: WB_NONE, pc_sel: PC_PC4, is_load: 1'b0, is_store: 1'b0, is_branch: 1'b0, rf_we: 1'b0
  };
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory handshake and control bundle.
interface multicycle_ctrl_if
  import multicycle_ctrl_pkg::*;
#(
  parameter int IW = INST_WIDTH,
  parameter int CW = CNT_WIDTH
) ();
  logic [IW-1:0] inst_i;
  logic          imem_ack_i;
  logic          dmem_ack_i;
  logic          br_taken_i;
  logic          imem_req_o;
  logic          ir_we_o;
  logic          dmem_req_o;
  logic          dmem_we_o;
  imm_sel_e      imm_sel_o;
  alu_op_e       alu_op_o;
  alu_a_sel_e    alu_a_sel_o;
  alu_b_sel_e    alu_b_sel_o;
  wb_sel_e       wb_sel_o;
  logic          rf_we_o;
  logic          pc_we_o;
  pc_sel_e       pc_sel_o;
  logic          illegal_o;
  logic [CW-1:0] instret_o;

  modport master (
    input  inst_i, imem_ack_i, dmem_ack_i, br_taken_i,
    output imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, imm_sel_o, alu_op_o, alu_a_sel_o,
           alu_b_sel_o, wb_sel_o, rf_we_o, pc_we_o, pc_sel_o, illegal_o, instret_o
  );
  modport slave (
    output inst_i, imem_ack_i, dmem_ack_i, br_taken_i,
    input  imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, imm_sel_o, alu_op_o, alu_a_sel_o,
           alu_b_sel_o, wb_sel_o, rf_we_o, pc_we_o, pc_sel_o, illegal_o, instret_o
  );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// multicycle_ctrl_decoder: combinational instruction -> control bundle and illegal flag.
module multicycle_ctrl_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [INST_WIDTH-1:0] inst_i,
  output ctrl_bundle_t          ctrl_o,
  output logic                  illegal_o
);
  logic [2:0] f3;
  logic       unused_bits;
  assign f3 = inst_i[14:12];
  assign unused_bits = ^{inst_i[INST_WIDTH-1:15]};
  always_comb begin
    ctrl_o = CTRL_RESET;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OP_REG: begin
        ctrl_o.alu_op = ALUOP_FUNCT7;
        ctrl_o.wb_sel = WB_ALU;
      end
      OP_IMM: begin
        ctrl_o.alu_op = ALUOP_FUNCT3;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_ITYPE;
        ctrl_o.wb_sel = WB_ALU;
      end
      OP_LOAD: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_ITYPE;
        ctrl_o.wb_sel = WB_MEM;
        ctrl_o.is_load = 1'b1;
        illegal_o = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OP_STORE: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_STYPE;
        ctrl_o.is_store = 1'b1;
        illegal_o = f3 > 3'd2;
      end
      OP_BRANCH: begin
        ctrl_o.alu_op = ALUOP_SUB;
        ctrl_o.imm_sel = IMM_BTYPE;
        ctrl_o.is_branch = 1'b1;
        illegal_o = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LUI: begin
        ctrl_o.alu_op = ALUOP_PASS_B;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_UTYPE;
        ctrl_o.wb_sel = WB_ALU;
      end
      OP_AUIPC: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.alu_a_sel = A_PC;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_UTYPE;
        ctrl_o.wb_sel = WB_ALU;
      end
      OP_JAL: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.alu_a_sel = A_PC;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_JTYPE;
        ctrl_o.wb_sel = WB_PC4;
        ctrl_o.pc_sel = PC_ALU;
      end
      OP_JALR: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.imm_sel = IMM_ITYPE;
        ctrl_o.wb_sel = WB_PC4;
        ctrl_o.pc_sel = PC_ALU;
        illegal_o = f3 != 3'd0;
      end
      default: illegal_o = 1'b1;
    endcase
    ctrl_o.rf_we = (ctrl_o.wb_sel != WB_NONE) && (inst_i[11:7] != 5'd0);
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with sticky trap and retire counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);
  ctrl_state_e          state_q;
  ctrl_bundle_t         ctrl_q, dec;
  logic                 dec_illegal;
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret_q;

  multicycle_ctrl_decoder u_dec (.inst_i(bus.inst_i), .ctrl_o(dec), .illegal_o(dec_illegal));

  assign retire = (state_q == S_EXEC && ctrl_q.is_branch) ||
                  (state_q == S_MEM && ctrl_q.is_store && bus.dmem_ack_i) ||
                  (state_q == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q <= CTRL_RESET;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
      case (state_q)
        S_FETCH: if (bus.imem_ack_i) state_q <= S_DECODE;
        S_DECODE: begin
          if (!dec_illegal) ctrl_q <= dec;
          state_q <= dec_illegal ? S_TRAP : S_EXEC;
        end
        S_EXEC: state_q <= ctrl_q.is_branch ? S_FETCH :
                           (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
        S_MEM: if (bus.dmem_ack_i) state_q <= ctrl_q.is_store ? S_FETCH : S_WB;
        S_WB: state_q <= S_FETCH;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Fetch request is gated by rst_n so it is low while reset is held, even though state sits in FETCH.
  assign bus.imem_req_o  = rst_n && (state_q == S_FETCH);
  assign bus.ir_we_o     = bus.imem_req_o && bus.imem_ack_i;
  assign bus.dmem_req_o  = state_q == S_MEM;
  assign bus.dmem_we_o   = bus.dmem_req_o && ctrl_q.is_store;
  assign bus.rf_we_o     = (state_q == S_WB) && ctrl_q.rf_we;
  assign bus.pc_we_o     = retire;
  assign bus.pc_sel_o    = (state_q == S_EXEC && ctrl_q.is_branch && bus.br_taken_i) ? PC_BRANCH : ctrl_q.pc_sel;
  assign bus.illegal_o   = state_q == S_TRAP;
  assign bus.imm_sel_o   = ctrl_q.imm_sel;
  assign bus.alu_op_o    = ctrl_q.alu_op;
  assign bus.alu_a_sel_o = ctrl_q.alu_a_sel;
  assign bus.alu_b_sel_o = ctrl_q.alu_b_sel;
  assign bus.wb_sel_o    = ctrl_q.wb_sel;
  assign bus.instret_o   = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle-by-cycle against a per-instruction schedule model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_instret = 0;

  typedef struct {
    logic       legal, branch, load, store, writes;
    imm_sel_e   imm;
    alu_op_e    alu;
    alu_a_sel_e a;
    alu_b_sel_e b;
    wb_sel_e    wb;
    pc_sel_e    pc;
  } m_t;

  // Expected controls straight from the instruction-class table.
  function automatic m_t model(input logic [31:0] i);
    m_t m;
    logic [2:0] f3;
    f3 = i[14:12];
    m.legal = 1'b1; m.branch = 1'b0; m.load = 1'b0; m.store = 1'b0; m.writes = 1'b1;
    m.imm = IMM_ITYPE; m.alu = ALUOP_ADD; m.a = A_RS1; m.b = B_IMM; m.wb = WB_ALU; m.pc = PC_PC4;
    case (i[6:0])
      7'h33: begin m.alu = ALUOP_FUNCT7; m.b = B_RS2; m.imm = IMM_RTYPE; end
      7'h13: m.alu = ALUOP_FUNCT3;
      7'h03: begin m.load = 1'b1; m.wb = WB_MEM; m.legal = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h23: begin m.store = 1'b1; m.imm = IMM_STYPE; m.wb = WB_NONE; m.writes = 1'b0; m.legal = f3 <= 3'd2; end
      7'h63: begin
        m.branch = 1'b1; m.alu = ALUOP_SUB; m.b = B_RS2; m.imm = IMM_BTYPE;
        m.wb = WB_NONE; m.writes = 1'b0; m.legal = !(f3 inside {3'd2, 3'd3});
      end
      7'h37: begin m.alu = ALUOP_PASS_B; m.imm = IMM_UTYPE; end
      7'h17: begin m.a = A_PC; m.imm = IMM_UTYPE; end
      7'h6F: begin m.a = A_PC; m.imm = IMM_JTYPE; m.wb = WB_PC4; m.pc = PC_ALU; end
      7'h67: begin m.wb = WB_PC4; m.pc = PC_ALU; m.legal = f3 == 3'd0; end
      default: m.legal = 1'b0;
    endcase
    return m;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [6:0] fl(input logic ireq, irw, dreq, dwe, rf, pc, ill);
    return {ill, pc, rf, dwe, dreq, irw, ireq};
  endfunction

  task automatic cyc(input logic ia, da, bt, input logic [6:0] e, input logic [1:0] epc, input logic ctl, input m_t m);
    @(negedge clk);
    bus.imem_ack_i = ia;
    bus.dmem_ack_i = da;
    bus.br_taken_i = bt;
    #1;
    n_vec++;
    chk("flags{ill,pc_we,rf_we,dwe,dreq,ir_we,ireq}",
        {bus.illegal_o, bus.pc_we_o, bus.rf_we_o, bus.dmem_we_o, bus.dmem_req_o, bus.ir_we_o, bus.imem_req_o}, e);
    chk("instret", bus.instret_o, ref_instret);
    if (e[5]) chk("pc_sel", bus.pc_sel_o, epc);
    if (ctl) begin
      chk("imm_sel", bus.imm_sel_o, m.imm);
      chk("alu_op", bus.alu_op_o, m.alu);
      chk("alu_a_sel", bus.alu_a_sel_o, m.a);
      chk("alu_b_sel", bus.alu_b_sel_o, m.b);
      chk("wb_sel", bus.wb_sel_o, m.wb);
    end
    if (e[5]) ref_instret++;
  endtask

  task automatic do_reset();
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("rst_flags", {bus.illegal_o, bus.pc_we_o, bus.rf_we_o, bus.dmem_we_o, bus.dmem_req_o, bus.ir_we_o, bus.imem_req_o}, 0);
    chk("rst_instret", bus.instret_o, 0);
    chk("rst_enums", {bus.imm_sel_o, bus.alu_op_o, bus.alu_a_sel_o, bus.alu_b_sel_o, bus.wb_sel_o},
        {IMM_RTYPE, ALUOP_NONE, A_RS1, B_RS2, WB_NONE});
    @(negedge clk);
    rst_n = 1'b1;
    ref_instret = 0;
  endtask

  task automatic run_inst(input logic [31:0] inst, input int wi, input int wd, input logic bt, input logic rst_mid);
    m_t m;
    logic wr;
    m = model(inst);
    wr = m.writes && (inst[11:7] != 5'd0);
    bus.inst_i = inst;
    for (int k = 0; k <= wi; k++) cyc(k == wi, 1'($urandom), 1'($urandom), fl(1, k == wi, 0, 0, 0, 0, 0), PC_PC4, 0, m);
    cyc(0, 1'($urandom), 1'($urandom), 0, PC_PC4, 0, m);
    if (!m.legal) begin
      for (int k = 0; k < 20; k++) cyc(1'($urandom), 1'($urandom), 1'($urandom), fl(0, 0, 0, 0, 0, 0, 1), PC_PC4, 0, m);
      do_reset();
      return;
    end
    if (m.branch) begin
      cyc(0, 1'($urandom), bt, fl(0, 0, 0, 0, 0, 1, 0), bt ? PC_BRANCH : PC_PC4, 1, m);
      return;
    end
    cyc(0, 1'($urandom), 1'($urandom), 0, PC_PC4, 1, m);
    if (m.load || m.store) begin
      for (int k = 0; k <= wd; k++) begin
        if (rst_mid) begin
          cyc(0, 0, 1'($urandom), fl(0, 0, 1, m.store, 0, 0, 0), PC_PC4, 1, m);
          #2;
          do_reset();
          return;
        end
        cyc(0, k == wd, 1'($urandom), fl(0, 0, 1, m.store, 0, m.store && k == wd, 0), PC_PC4, 1, m);
      end
      if (m.store) return;
    end
    cyc(0, 1'($urandom), 1'($urandom), fl(0, 0, 0, 0, wr, 1, 0), m.pc, 1, m);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] i;
    logic [2:0] f3;
    int c;
    i = $urandom;
    c = $urandom_range(0, 41);
    f3 = i[14:12];
    case (c % 9)
      0: i[6:0] = 7'h33;
      1: i[6:0] = 7'h13;
      2: begin i[6:0] = 7'h03; if (f3 inside {3'd3, 3'd6, 3'd7}) f3 = 3'd2; end
      3: begin i[6:0] = 7'h23; f3 = f3 % 3'd3; end
      4: begin i[6:0] = 7'h63; if (f3 inside {3'd2, 3'd3}) f3 = f3 ^ 3'b100; end
      5: i[6:0] = 7'h37;
      6: i[6:0] = 7'h17;
      7: i[6:0] = 7'h6F;
      default: begin i[6:0] = 7'h67; f3 = 3'd0; end
    endcase
    if (c == 40) i[6:0] = 7'h73;
    if (c == 41) begin i[6:0] = 7'h67; f3 = 3'($urandom_range(1, 7)); end
    if (c % 4 == 0) i[11:7] = 5'd0;
    i[14:12] = f3;
    return i;
  endfunction

  initial begin
    bus.inst_i = '0;
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;
    bus.br_taken_i = 1'b0;
    chk("pin_add_aluop", model(32'h002081B3).alu, ALUOP_FUNCT7);
    chk("pin_lw_wb", model(32'h0040A283).wb, WB_MEM);
    chk("pin_beq_branch", model(32'h00208463).branch, 1);
    chk("pin_ffff_illegal", model(32'hFFFFFFFF).legal, 0);
    do_reset();
    run_inst(32'h002081B3, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("add_instret", bus.instret_o, 1);
    run_inst(32'h0040A283, 0, 2, 0, 0);
    run_inst(32'h00208463, 0, 0, 1, 0);
    run_inst(32'h00208463, 1, 0, 0, 0);
    run_inst(32'h00100013, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("seq_instret", bus.instret_o, 5);
    run_inst(32'hFFFFFFFF, 0, 0, 0, 0);
    run_inst(32'h002081B3, 2, 0, 0, 0);
    run_inst(32'h0040A283, 0, 5, 0, 1);
    for (int n = 0; n < 300; n++) run_inst(gen(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
